// File: rtl/sd_data_master_pkg.sv
// Shared constants for the SD data master: state encodings, host start codes, int_status bit map.
package sd_data_master_pkg;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_PREFILL   = 6'b000010,
    ST_START     = 6'b000100,
    ST_WAIT_BUSY = 6'b001000,
    ST_XFER      = 6'b010000,
    ST_ABORT     = 6'b100000
  } state_e;

  localparam logic [1:0] START_NONE  = 2'b00;
  localparam logic [1:0] START_WRITE = 2'b01;
  localparam logic [1:0] START_READ  = 2'b10;
  localparam logic [1:0] START_ABORT = 2'b11;

  localparam int INT_W = 5;
  localparam logic [2:0] INT_DATA_CC    = 3'd0;
  localparam logic [2:0] INT_DATA_EI    = 3'd1;
  localparam logic [2:0] INT_DATA_CCRCE = 3'd2;
  localparam logic [2:0] INT_DATA_CFE   = 3'd3;
  localparam logic [2:0] INT_DATA_CTE   = 3'd4;

  // Last WAIT_BUSY cycle index before giving up on the host.
  localparam logic [1:0] BUSY_WAIT_LAST = 2'd3;

  // Every error cause also raises the summary error bit.
  function automatic logic [INT_W-1:0] err_bits(input logic [2:0] cause);
    logic [INT_W-1:0] b;
    b = '0;
    b[cause] = 1'b1;
    b[INT_DATA_EI] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/sd_data_master_if.sv
// Register/host/FIFO-facing signal bundle of the SD data master.
interface sd_data_master_if #(
  parameter int TIMEOUT_W = 24
);
  logic                 start_tx_i;
  logic                 start_rx_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 tx_fifo_empty_i;
  logic                 rx_fifo_full_i;
  logic                 xfr_busy_i;
  logic                 xfr_crc_ok_i;
  logic                 clear_irq_i;
  logic [1:0]           start_o;
  logic                 fifo_rst_o;
  logic                 busy_o;
  logic [4:0]           int_status_o;

  modport master (
    input  start_tx_i, start_rx_i, timeout_i, tx_fifo_empty_i, rx_fifo_full_i,
           xfr_busy_i, xfr_crc_ok_i, clear_irq_i,
    output start_o, fifo_rst_o, busy_o, int_status_o
  );

  modport slave (
    output start_tx_i, start_rx_i, timeout_i, tx_fifo_empty_i, rx_fifo_full_i,
           xfr_busy_i, xfr_crc_ok_i, clear_irq_i,
    input  start_o, fifo_rst_o, busy_o, int_status_o
  );
endinterface

// File: rtl/sd_data_master_timeout_counter.sv
// Saturating down-counter guarding a transfer; expired only when a non-zero reload is programmed.
module sd_timeout_counter #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic [TIMEOUT_W-1:0] reload_i,
  output logic                 expired_o
);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= reload_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - TIMEOUT_W'(1);
    end
  end

  assign expired_o = (count_q == '0) && (reload_i != '0);

endmodule

// File: rtl/sd_data_master.sv
// SD data transfer sequencer: start pulses -> host start codes, supervision, sticky irq status.
// Optional TX prefill wait is built when SDC_TX_PREFILL_EN is defined.
module sd_data_master
  import sd_data_master_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input logic             sd_clk,
  input logic             rst,
  sd_data_master_if.master bus
);

  state_e           state_q;
  logic             dir_wr_q;
  logic [1:0]       start_q;
  logic             fifo_rst_q;
  logic             busy_q;
  logic [1:0]       wait_cnt_q;
  logic [INT_W-1:0] irq_q;

  logic [INT_W-1:0] irq_set;
  logic             abort_req;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_expired;

  assign tmo_load = ((state_q == ST_IDLE) && (bus.start_tx_i || bus.start_rx_i))
                  || (state_q == ST_START);
  assign tmo_en   = (state_q == ST_PREFILL) || (state_q == ST_WAIT_BUSY)
                  || (state_q == ST_XFER);

  sd_timeout_counter #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
    .sd_clk    (sd_clk),
    .rst       (rst),
    .load_i    (tmo_load),
    .en_i      (tmo_en),
    .reload_i  (bus.timeout_i),
    .expired_o (tmo_expired)
  );

  // Error causes are prioritised here so the FSM only needs abort_req.
  always_comb begin
    irq_set   = '0;
    abort_req = 1'b0;
    case (state_q)
`ifdef SDC_TX_PREFILL_EN
      ST_PREFILL: begin
        if (tmo_expired) begin
          irq_set   = err_bits(INT_DATA_CTE);
          abort_req = 1'b1;
        end
      end
`endif
      ST_WAIT_BUSY: begin
        if (!bus.xfr_busy_i && (wait_cnt_q == BUSY_WAIT_LAST)) begin
          irq_set[INT_DATA_EI] = 1'b1;
          abort_req            = 1'b1;
        end
      end
      ST_XFER: begin
        if (tmo_expired) begin
          irq_set   = err_bits(INT_DATA_CTE);
          abort_req = 1'b1;
        end else if (dir_wr_q && bus.tx_fifo_empty_i) begin
          irq_set   = err_bits(INT_DATA_CFE);
          abort_req = 1'b1;
        end else if (!dir_wr_q && bus.rx_fifo_full_i) begin
          irq_set   = err_bits(INT_DATA_CFE);
          abort_req = 1'b1;
        end else if (!bus.xfr_busy_i) begin
          if (bus.xfr_crc_ok_i) irq_set[INT_DATA_CC] = 1'b1;
          else                  irq_set = err_bits(INT_DATA_CCRCE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_wr_q   <= 1'b0;
      start_q    <= START_NONE;
      fifo_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      fifo_rst_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_tx_i) begin
            dir_wr_q <= 1'b1;
            busy_q   <= 1'b1;
`ifdef SDC_TX_PREFILL_EN
            state_q  <= ST_PREFILL;
`else
            state_q  <= ST_START;
            start_q  <= START_WRITE;
`endif
          end else if (bus.start_rx_i) begin
            dir_wr_q   <= 1'b0;
            busy_q     <= 1'b1;
            fifo_rst_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
`ifdef SDC_TX_PREFILL_EN
        ST_PREFILL: begin
          if (abort_req) begin
            state_q <= ST_ABORT;
            start_q <= START_ABORT;
          end else if (!bus.tx_fifo_empty_i) begin
            state_q <= ST_START;
            start_q <= START_WRITE;
          end
        end
`endif
        // A write code is already on the wire here; a read code follows its flush pulse.
        ST_START: begin
          start_q    <= dir_wr_q ? START_NONE : START_READ;
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          start_q <= START_NONE;
          if (bus.xfr_busy_i) begin
            state_q <= ST_XFER;
          end else if (abort_req) begin
            state_q <= ST_ABORT;
            start_q <= START_ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        ST_XFER: begin
          if (abort_req) begin
            state_q <= ST_ABORT;
            start_q <= START_ABORT;
          end else if (!bus.xfr_busy_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ABORT: begin
          if (!bus.xfr_busy_i) begin
            state_q <= ST_IDLE;
            start_q <= START_NONE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= START_NONE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sets land after the clear so a same-cycle event is never lost.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      irq_q <= '0;
    end else begin
      irq_q <= (bus.clear_irq_i ? '0 : irq_q) | irq_set;
    end
  end

  assign bus.start_o      = start_q;
  assign bus.fifo_rst_o   = fifo_rst_q;
  assign bus.busy_o       = busy_q;
  assign bus.int_status_o = irq_q;

endmodule

// File: doc/sd_data_master.md
Name: sd_data_master

Overview:
- sd_clk-domain transfer sequencer that sits directly upstream of the serial data host.
- Converts register-level write/read start pulses into the host's 2-bit start command.
- Supervises the host's busy and crc_ok outputs, watches the TX/RX FIFO levels and a programmable timeout.
- Produces sticky data-interrupt status for the register block; aborts the host with start code 2'b11 on any error.

Parameters:
- TIMEOUT_W, 24, width of timeout reload value and internal cycle counter.

Ports:
- sd_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start_tx_i  in  1  one-cycle pulse, begin block write(s)
- start_rx_i  in  1  one-cycle pulse, begin block read(s)
- timeout_i  in  TIMEOUT_W  max sd_clk cycles per transfer; 0 = timeout disabled
- tx_fifo_empty_i  in  1  TX FIFO empty
- rx_fifo_full_i  in  1  RX FIFO full
- xfr_busy_i  in  1  host busy
- xfr_crc_ok_i  in  1  host crc_ok
- clear_irq_i  in  1  one-cycle pulse, clears int_status_o
- start_o  out  2  to host start: 00 none, 01 write, 10 read, 11 abort
- fifo_rst_o  out  1  one-cycle FIFO flush pulse issued at transfer start
- busy_o  out  1  high whenever state != IDLE
- int_status_o  out  5  sticky: [0] complete, [1] error, [2] CRC fail, [3] FIFO under/overrun, [4] timeout

Behaviour:
- Reset (async): state IDLE; start_o=00, fifo_rst_o=0, busy_o=0, int_status_o=0, counter=0. A reset mid-transfer returns to IDLE with no abort code issued.
- All outputs are registered.
- States (one-hot, 6 bits): IDLE, PREFILL, START, WAIT_BUSY, XFER, ABORT.
- IDLE:
  - start_tx_i -> latch dir=write; fifo_rst_o=1 only when dir=read (a write flush would discard prefilled data); next PREFILL.
  - start_rx_i -> latch dir=read; fifo_rst_o=1; next START.
  - Both pulses high together -> write wins.
  - Start pulses in any non-IDLE state are ignored.
- PREFILL: wait for !tx_fifo_empty_i, then go to START. Timeout counts here.
- START: start_o=01 (write) or 10 (read) for exactly one cycle; counter loaded with timeout_i; next WAIT_BUSY.
  - Latency with prefill satisfied: start_rx_i at cycle N -> fifo_rst_o at N+1, start_o=10 at N+2.
- WAIT_BUSY: start_o=00; on xfr_busy_i=1 go to XFER. If busy is not seen within 4 cycles -> ABORT with error.
- XFER:
  - xfr_busy_i falls -> IDLE. Set bit0 if xfr_crc_ok_i=1, else set bits 2 and 1.
  - Error checks, in priority order (first match wins):
    - timeout: counter reaches 0 with timeout_i != 0 -> bits 4, 1;
    - dir=write and tx_fifo_empty_i -> bits 3, 1;
    - dir=read and rx_fifo_full_i -> bits 3, 1.
  - Any error -> ABORT.
  - Busy fall and an error in the same cycle: the error wins.
- ABORT: start_o=11, held until xfr_busy_i=0; then start_o=00 and go to IDLE. The complete bit is never set on an aborted transfer.
- Counter: decrements by 1 per cycle in PREFILL/WAIT_BUSY/XFER, saturates at 0, and never wraps.
  - In PREFILL the counter is loaded from timeout_i on IDLE exit.
- int_status_o:
  - Bits are OR-set and only cleared by clear_irq_i.
  - When a clear and a set land in the same cycle, the set wins.
  - Bit 1 = OR of all error causes.

Optional Feature:
- Macro: SDC_TX_PREFILL_EN.
- Defined: PREFILL state present; a write waits for TX FIFO non-empty (timeout applies).
- Undefined: PREFILL removed; a write goes IDLE -> START directly, and start_tx_i at N gives start_o=01 at N+1.

Decomposition:
- sd_defines.v holds the shared constants:
  - state one-hot encodings;
  - start codes START_NONE/WRITE/READ/ABORT;
  - int_status bit indices INT_DATA_CC, INT_DATA_EI, INT_DATA_CCRCE, INT_DATA_CFE, INT_DATA_CTE.
- One natural sub-module, sd_timeout_counter:
  - loads on load pulse, decrements on enable, saturates at 0;
  - outputs expired = (count==0 && reload!=0).

Test Plan:
- Read, timeout_i=1000: start_rx_i; bench host raises busy 2 cycles later for 300 cycles, then crc_ok=1 -> start_o=10 for one cycle, fifo_rst_o pulse, int_status_o=5'b00001, busy_o low afterwards.
- Write with CRC failure: start_tx_i, FIFO non-empty, host busy 200 cycles, crc_ok=0 -> start_o=01, int_status_o=5'b00110.
- TX underrun: tx_fifo_empty_i rises mid-XFER -> start_o=11 held until host busy drops; int_status_o=5'b01010, bit0 clear.
- Timeout: timeout_i=50, host busy never drops -> abort on the 50th XFER cycle, int_status_o=5'b10010. Repeat with timeout_i=0 -> no timeout.
- Simultaneous start_tx_i and start_rx_i -> write issued. A start pulse while busy_o=1 -> ignored, no second start_o.
- Asynchronous rst asserted mid-XFER -> all outputs 0 immediately. Also cover clear_irq_i coinciding with a completion -> bit0 remains set.
